// File: rtl/song_autoplay_ctrl_if.sv
// Bus between the auto-play sequencer and its surroundings: timebase, transport
// pulses, live key, song ROM port and tone-generator note output.
interface song_autoplay_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              TICK;
    logic              PLAY;
    logic              STOP;
    logic [3:0]        KEY_NOTE;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [3:0]        note_out;
    logic              src;
    logic              playing;
    logic              done;

    modport master (
        output TICK, PLAY, STOP, KEY_NOTE, rom_data,
        input  rom_addr, note_out, src, playing, done
    );

    modport slave (
        input  TICK, PLAY, STOP, KEY_NOTE, rom_data,
        output rom_addr, note_out, src, playing, done
    );
endinterface

// File: rtl/song_autoplay_ctrl.sv
// Song auto-play sequencer: walks a {note,dur} ROM, times notes against TICK and
// shares the tone-generator note bus with the live keyboard (live keys win).
module song_autoplay_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int GAP_TICKS = 1,
    parameter bit LOOP      = 1'b0
) (
    input logic                 CLK,
    input logic                 RESET,
    song_autoplay_ctrl_if.slave bus
);
    localparam logic [3:0]        NOTE_NONE = 4'd0;
    localparam logic [7:0]        GAP_INIT  = 8'(GAP_TICKS);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        NOTE  = 3'd3,
        GAP   = 3'd4,
        PAUSE = 3'd5
    } state_t;

    state_t            state_r;
    state_t            saved_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [3:0]        note_reg_r;
    logic [3:0]        tcnt_r;
    logic [7:0]        gcnt_r;
    logic [3:0]        note_out_r;
    logic              src_r;
    logic              playing_r;
    logic              done_r;

    logic [3:0]        rom_note_s;
    logic [3:0]        rom_dur_s;
    state_t            end_state_s;
    logic              end_done_s;
    state_t            adv_state_s;
    logic [ADDR_W-1:0] adv_addr_s;
    logic              adv_done_s;

    assign rom_note_s = bus.rom_data[7:4];
    assign rom_dur_s  = bus.rom_data[3:0];

    // End-of-song and next-entry outcomes; the last address is an end, never a wrap
    always_comb begin
        end_state_s = IDLE;
        end_done_s  = 1'b1;
        adv_state_s = FETCH;
        adv_addr_s  = rom_addr_r + ADDR_ONE;
        adv_done_s  = 1'b0;
        if (LOOP) begin
            end_state_s = FETCH;
            end_done_s  = 1'b0;
        end else begin
            end_state_s = IDLE;
            end_done_s  = 1'b1;
        end
        if (rom_addr_r == ADDR_LAST) begin
            adv_state_s = end_state_s;
            adv_addr_s  = ADDR_ZERO;
            adv_done_s  = end_done_s;
        end else begin
            adv_state_s = FETCH;
            adv_addr_s  = rom_addr_r + ADDR_ONE;
            adv_done_s  = 1'b0;
        end
    end

    // Playback FSM, note timing and registered note-bus arbitration
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= IDLE;
            saved_r    <= IDLE;
            rom_addr_r <= ADDR_ZERO;
            note_reg_r <= NOTE_NONE;
            tcnt_r     <= 4'd0;
            gcnt_r     <= 8'd0;
            note_out_r <= NOTE_NONE;
            src_r      <= 1'b0;
            playing_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            playing_r <= (state_r != IDLE);

            if (bus.KEY_NOTE != NOTE_NONE) begin
                note_out_r <= bus.KEY_NOTE;
                src_r      <= 1'b0;
            end else if (state_r == NOTE) begin
                note_out_r <= note_reg_r;
                src_r      <= 1'b1;
            end else begin
                note_out_r <= NOTE_NONE;
                src_r      <= 1'b0;
            end

            // STOP outranks PLAY everywhere, including IDLE where both are dropped
            if (bus.STOP) begin
                if (state_r != IDLE) begin
                    state_r    <= IDLE;
                    rom_addr_r <= ADDR_ZERO;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.PLAY) begin
                            state_r    <= FETCH;
                            rom_addr_r <= ADDR_ZERO;
                        end
                    end
                    FETCH: state_r <= LOAD;
                    LOAD: begin
                        if (rom_dur_s == 4'd0) begin
                            state_r    <= end_state_s;
                            rom_addr_r <= ADDR_ZERO;
                            done_r     <= end_done_s;
                        end else begin
                            note_reg_r <= rom_note_s;
                            tcnt_r     <= rom_dur_s;
                            state_r    <= NOTE;
                        end
                    end
                    NOTE: begin
                        if (bus.PLAY) begin
                            saved_r <= NOTE;
                            state_r <= PAUSE;
                        end else if (bus.TICK) begin
                            if (tcnt_r == 4'd1) begin
                                if (GAP_INIT == 8'd0) begin
                                    state_r    <= adv_state_s;
                                    rom_addr_r <= adv_addr_s;
                                    done_r     <= adv_done_s;
                                end else begin
                                    gcnt_r  <= GAP_INIT;
                                    state_r <= GAP;
                                end
                            end else begin
                                tcnt_r <= tcnt_r - 4'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (bus.PLAY) begin
                            saved_r <= GAP;
                            state_r <= PAUSE;
                        end else if (bus.TICK) begin
                            if (gcnt_r == 8'd1) begin
                                state_r    <= adv_state_s;
                                rom_addr_r <= adv_addr_s;
                                done_r     <= adv_done_s;
                            end else begin
                                gcnt_r <= gcnt_r - 8'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.PLAY) begin
                            state_r <= saved_r;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        rom_addr_r <= ADDR_ZERO;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = rom_addr_r;
    assign bus.note_out = note_out_r;
    assign bus.src      = src_r;
    assign bus.playing  = playing_r;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_song_autoplay_ctrl.sv
// Directed bench: a vector table drives the main ADDR_W=6 instance; hand-written
// sequences cover async reset mid-note and last-address end with LOOP=0/1.
module tb_song_autoplay_ctrl;
    logic CLK = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    song_autoplay_ctrl_if #(.ADDR_W(6)) ifa ();
    song_autoplay_ctrl_if #(.ADDR_W(2)) ifb ();
    song_autoplay_ctrl_if #(.ADDR_W(2)) ifc ();

    song_autoplay_ctrl #(.ADDR_W(6), .GAP_TICKS(1), .LOOP(1'b0)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
    song_autoplay_ctrl #(.ADDR_W(2), .GAP_TICKS(1), .LOOP(1'b0)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));
    song_autoplay_ctrl #(.ADDR_W(2), .GAP_TICKS(1), .LOOP(1'b1)) dut_c (.CLK(CLK), .RESET(RESET), .bus(ifc));

    logic [7:0] rom_a [0:63];
    logic [7:0] rom_b [0:3];

    // Synchronous song ROMs: data valid one cycle after the address
    always_ff @(posedge CLK) begin
        ifa.rom_data <= rom_a[ifa.rom_addr];
        ifb.rom_data <= rom_b[ifb.rom_addr];
        ifc.rom_data <= rom_b[ifc.rom_addr];
    end

    int done_a = 0;
    int done_b = 0;
    int done_c = 0;

    // Count high cycles of each done output
    always @(negedge CLK) begin
        if (ifa.done) done_a <= done_a + 1;
        if (ifb.done) done_b <= done_b + 1;
        if (ifc.done) done_c <= done_c + 1;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", what, act, exp);
        end
    endtask

    typedef struct {
        logic       play;
        logic       stop;
        logic       tick;
        logic [3:0] key;
        int         reps;
        logic [3:0] note;
        logic       src;
        logic [5:0] addr;
        logic       playing;
        int         dones;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic play, input logic stop, input logic tick,
                                input logic [3:0] key, input int reps, input logic [3:0] note,
                                input logic src, input logic [5:0] addr, input logic playing,
                                input int dones);
        vec_t v;
        v.play = play; v.stop = stop; v.tick = tick; v.key = key; v.reps = reps;
        v.note = note; v.src = src; v.addr = addr; v.playing = playing; v.dones = dones;
        return v;
    endfunction

    // One pulse cycle on instance A (key held), then three quiet cycles to settle
    task automatic apply_a(input logic play, input logic stop, input logic tick, input logic [3:0] key);
        @(negedge CLK);
        ifa.PLAY = play; ifa.STOP = stop; ifa.TICK = tick; ifa.KEY_NOTE = key;
        @(negedge CLK);
        ifa.PLAY = 1'b0; ifa.STOP = 1'b0; ifa.TICK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic apply_bc(input logic play, input logic tick);
        @(negedge CLK);
        ifb.PLAY = play; ifb.TICK = tick;
        ifc.PLAY = play; ifc.TICK = tick;
        @(negedge CLK);
        ifb.PLAY = 1'b0; ifb.TICK = 1'b0;
        ifc.PLAY = 1'b0; ifc.TICK = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] note, input logic [1:0] addr,
                         input logic playing, input int dones);
        chk({tag, " b.note_out"}, ifb.note_out, note);
        chk({tag, " b.rom_addr"}, ifb.rom_addr, addr);
        chk({tag, " b.playing"}, ifb.playing, playing);
        chk({tag, " b.done"}, done_b, dones);
    endtask

    task automatic chk_c(input string tag, input logic [3:0] note, input logic src,
                         input logic [1:0] addr, input int dones);
        chk({tag, " c.note_out"}, ifc.note_out, note);
        chk({tag, " c.src"}, ifc.src, src);
        chk({tag, " c.rom_addr"}, ifc.rom_addr, addr);
        chk({tag, " c.done"}, done_c, dones);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom_a[i] = 8'h00;
        rom_a[0] = 8'h12;
        rom_a[1] = 8'h31;
        rom_a[2] = 8'h00;
        rom_b[0] = 8'h11;
        rom_b[1] = 8'h21;
        rom_b[2] = 8'h31;
        rom_b[3] = 8'h41;

        ifa.PLAY = 1'b0; ifa.STOP = 1'b0; ifa.TICK = 1'b0; ifa.KEY_NOTE = 4'd0;
        ifb.PLAY = 1'b0; ifb.STOP = 1'b0; ifb.TICK = 1'b0; ifb.KEY_NOTE = 4'd0;
        ifc.PLAY = 1'b0; ifc.STOP = 1'b0; ifc.TICK = 1'b0; ifc.KEY_NOTE = 4'd0;

        //      play stop tick key reps  note src addr playing dones
        vecs.push_back(mk(0, 0, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 0));  // idle
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 0));  // basic song
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd1, 1, 6'd0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd3, 1, 6'd1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));  // end: done
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));  // live override
        vecs.push_back(mk(0, 0, 0, 4'd5, 1,  4'd5, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd5, 1,  4'd5, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd3, 1, 6'd1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));  // STOP mid-GAP
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));  // pause in NOTE
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 10, 4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd3, 1, 6'd1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));  // STOP+PLAY from NOTE
        vecs.push_back(mk(1, 1, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));  // STOP+PLAY from IDLE
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd7, 1,  4'd7, 0, 6'd0, 0, 1));  // live key while idle
        vecs.push_back(mk(0, 0, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));  // pause in GAP
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd1, 1, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 3,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'd0, 1,  4'd0, 0, 6'd0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 4'd0, 1,  4'd3, 1, 6'd1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 4'd0, 1,  4'd0, 0, 6'd0, 0, 1));

        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset note_out", ifa.note_out, 4'd0);
        chk("reset src", ifa.src, 1'b0);
        chk("reset rom_addr", ifa.rom_addr, 6'd0);
        chk("reset playing", ifa.playing, 1'b0);
        chk("reset done", ifa.done, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                apply_a(vecs[i].play, vecs[i].stop, vecs[i].tick, vecs[i].key);
            end
            chk($sformatf("vec%0d note_out", i), ifa.note_out, vecs[i].note);
            chk($sformatf("vec%0d src", i), ifa.src, vecs[i].src);
            chk($sformatf("vec%0d rom_addr", i), ifa.rom_addr, vecs[i].addr);
            chk($sformatf("vec%0d playing", i), ifa.playing, vecs[i].playing);
            chk($sformatf("vec%0d done count", i), done_a, vecs[i].dones);
        end

        // Asynchronous reset in the middle of a note, checked before any clock edge
        apply_a(1'b1, 1'b0, 1'b1, 4'd0);
        chk("pre-reset note_out", ifa.note_out, 4'd1);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async reset note_out", ifa.note_out, 4'd0);
        chk("async reset src", ifa.src, 1'b0);
        chk("async reset playing", ifa.playing, 1'b0);
        chk("async reset done", ifa.done, 1'b0);
        chk("async reset rom_addr", ifa.rom_addr, 6'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        chk("after reset note_out", ifa.note_out, 4'd0);
        chk("after reset done count", done_a, 1);

        // Last-address end on ADDR_W=2: B stops with done, C loops without it
        apply_bc(1'b1, 1'b0);
        chk_b("start", 4'd1, 2'd0, 1'b1, 0);
        chk_c("start", 4'd1, 1'b1, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            apply_bc(1'b0, 1'b1);
            chk_b($sformatf("gap%0d", k), 4'd0, 2'(k), 1'b1, 0);
            chk_c($sformatf("gap%0d", k), 4'd0, 1'b0, 2'(k), 0);
            apply_bc(1'b0, 1'b1);
            if (k < 3) begin
                chk_b($sformatf("entry%0d", k + 1), 4'(k + 2), 2'(k + 1), 1'b1, 0);
                chk_c($sformatf("entry%0d", k + 1), 4'(k + 2), 1'b1, 2'(k + 1), 0);
            end else begin
                chk_b("end", 4'd0, 2'd0, 1'b0, 1);
                chk_c("loop", 4'd1, 1'b1, 2'd0, 0);
            end
        end
        apply_bc(1'b0, 1'b1);
        chk_b("after end 1", 4'd0, 2'd0, 1'b0, 1);
        chk_c("loop gap", 4'd0, 1'b0, 2'd0, 0);
        apply_bc(1'b0, 1'b1);
        chk_b("after end 2", 4'd0, 2'd0, 1'b0, 1);
        chk_c("loop entry1", 4'd2, 1'b1, 2'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
